// File: rtl/ula_sequencial.sv
// ula_sequencial: multi-cycle ALU behind a start/ready/valid handshake.
// Simple ops finish 1 cycle after acceptance. Multiply (shift-add) and
// divide (restoring) iterate one bit per cycle, taking LARGURA cycles.
// Optional feature macro: ULA_SEQ_DIVISOR_EN. When it is undefined the
// divider is absent and opcodes 0011/0100 are reported as invalid.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   Inicio         - start request, sampled only while Pronto=1
//   A, B, Sel_Op   - operands and opcode, captured on acceptance
//   Pronto         - idle, can accept a new operation
//   Valido         - one-cycle pulse when Resultado and flags are updated
//   Resultado      - 2*LARGURA result, held until the next Valido
//   Maior/Menor/Igual - unsigned compare of captured A vs B
//   Carry          - add carry-out / subtract borrow
//   Div_Zero       - divide op with B=0
//   Erro           - unsupported opcode
module ula_sequencial #(
  parameter int unsigned LARGURA = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Inicio,
  input  logic [LARGURA-1:0]     A,
  input  logic [LARGURA-1:0]     B,
  input  logic [3:0]             Sel_Op,
  output logic                   Pronto,
  output logic                   Valido,
  output logic [2*LARGURA-1:0]   Resultado,
  output logic                   Maior,
  output logic                   Menor,
  output logic                   Igual,
  output logic                   Carry,
  output logic                   Div_Zero,
  output logic                   Erro
);

  localparam int unsigned W  = LARGURA;
  localparam int unsigned RW = 2 * LARGURA;
  localparam int unsigned CW = $clog2(LARGURA + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_QUO  = 4'b0011;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOTA = 4'b1011;

  typedef enum logic {OCIOSO, EXECUTA} estado_t;

  // Registered state
  estado_t         r_estado;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [3:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_hi;       // mul: product high half / div: partial remainder
  logic [W-1:0]    r_lo;       // mul: multiplier, shifts out / div: dividend -> quotient
  logic            r_pronto;
  logic            r_valido;
  logic [RW-1:0]   r_resultado;
  logic            r_maior, r_menor, r_igual, r_carry, r_div_zero, r_erro;

  // Next-state values
  estado_t         w_estado;
  logic [W-1:0]    w_a, w_b, w_hi, w_lo;
  logic [3:0]      w_op;
  logic [CW-1:0]   w_cnt;
  logic            w_pronto, w_valido;
  logic [RW-1:0]   w_resultado;
  logic            w_maior, w_menor, w_igual, w_carry, w_div_zero, w_erro;

  // Datapath
  logic [W:0]      w_soma;
  logic [W-1:0]    w_dif;
  logic [W-1:0]    w_logica;
  logic [W:0]      w_mul_soma;
  logic [W-1:0]    w_mul_hi, w_mul_lo;
  logic            w_longa;
  logic            w_ultimo;
  logic [RW-1:0]   w_res_op;
  logic            w_carry_op, w_dz_op, w_erro_op;

  assign w_soma = (W+1)'(r_a) + (W+1)'(r_b);
  assign w_dif  = r_a - r_b;

  // Shift-add step: add multiplicand into the high half, then shift {hi,lo} right.
  assign w_mul_soma = (W+1)'(r_hi) + (r_lo[0] ? (W+1)'(r_a) : (W+1)'(0));
  assign w_mul_hi   = w_mul_soma[W:1];
  assign w_mul_lo   = {w_mul_soma[0], r_lo[W-1:1]};

`ifdef ULA_SEQ_DIVISOR_EN
  logic [W:0]      w_div_desl;
  logic            w_div_ge;
  logic [W-1:0]    w_div_hi, w_div_lo;

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  // With B=0 every step fits, giving all-ones quotient and remainder = A.
  assign w_div_desl = {r_hi, r_lo[W-1]};
  assign w_div_ge   = w_div_desl >= (W+1)'(r_b);
  assign w_div_hi   = w_div_ge ? W'(w_div_desl - (W+1)'(r_b)) : w_div_desl[W-1:0];
  assign w_div_lo   = {r_lo[W-2:0], w_div_ge};
  assign w_longa    = (r_op == OP_MUL) || (r_op == OP_QUO) || (r_op == OP_REM);
`else
  assign w_longa    = (r_op == OP_MUL);
`endif

  assign w_ultimo = (r_cnt == CW'(W - 1));

  // Bitwise ops, kept at W bits so inversion never reaches the upper half
  always_comb begin
    w_logica = '0;
    case (r_op)
      OP_AND:  w_logica = r_a & r_b;
      OP_OR:   w_logica = r_a | r_b;
      OP_NAND: w_logica = ~(r_a & r_b);
      OP_NOR:  w_logica = ~(r_a | r_b);
      OP_XOR:  w_logica = r_a ^ r_b;
      OP_NOTA: w_logica = ~r_a;
      default: w_logica = '0;
    endcase
  end

  // Final result and op-specific flags for the captured opcode
  always_comb begin
    w_res_op   = '0;
    w_carry_op = 1'b0;
    w_dz_op    = 1'b0;
    w_erro_op  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res_op   = RW'(w_soma);
        w_carry_op = w_soma[W];
      end
      OP_SUB: begin
        w_res_op   = RW'(w_dif);
        w_carry_op = (r_a < r_b);
      end
      OP_MUL:  w_res_op = {w_mul_hi, w_mul_lo};
`ifdef ULA_SEQ_DIVISOR_EN
      OP_QUO: begin
        w_res_op = RW'(w_div_lo);
        w_dz_op  = (r_b == '0);
      end
      OP_REM: begin
        w_res_op = RW'(w_div_hi);
        w_dz_op  = (r_b == '0);
      end
`endif
      OP_CMP:  w_res_op = '0;
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_NOTA:
               w_res_op = RW'(w_logica);
      default: w_erro_op = 1'b1;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    w_estado    = r_estado;
    w_a         = r_a;
    w_b         = r_b;
    w_op        = r_op;
    w_cnt       = r_cnt;
    w_hi        = r_hi;
    w_lo        = r_lo;
    w_pronto    = r_pronto;
    w_valido    = 1'b0;
    w_resultado = r_resultado;
    w_maior     = r_maior;
    w_menor     = r_menor;
    w_igual     = r_igual;
    w_carry     = r_carry;
    w_div_zero  = r_div_zero;
    w_erro      = r_erro;
    case (r_estado)
      OCIOSO: begin
        w_pronto = 1'b1;
        if (Inicio) begin
          w_a      = A;
          w_b      = B;
          w_op     = Sel_Op;
          w_cnt    = '0;
          w_hi     = '0;
          w_lo     = (Sel_Op == OP_MUL) ? B : A;
          w_pronto = 1'b0;
          w_estado = EXECUTA;
        end
      end
      EXECUTA: begin
        if (w_longa) begin
          w_cnt = r_cnt + CW'(1);
`ifdef ULA_SEQ_DIVISOR_EN
          if (r_op == OP_MUL) begin
            w_hi = w_mul_hi;
            w_lo = w_mul_lo;
          end else begin
            w_hi = w_div_hi;
            w_lo = w_div_lo;
          end
`else
          w_hi = w_mul_hi;
          w_lo = w_mul_lo;
`endif
        end
        if (!w_longa || w_ultimo) begin
          w_resultado = w_res_op;
          w_carry     = w_carry_op;
          w_div_zero  = w_dz_op;
          w_erro      = w_erro_op;
          w_maior     = (r_a > r_b);
          w_menor     = (r_a < r_b);
          w_igual     = (r_a == r_b);
          w_valido    = 1'b1;
          w_pronto    = 1'b1;
          w_estado    = OCIOSO;
        end
      end
      default: begin
        w_estado = OCIOSO;
        w_pronto = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado    <= OCIOSO;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_pronto    <= 1'b1;
      r_valido    <= 1'b0;
      r_resultado <= '0;
      r_maior     <= 1'b0;
      r_menor     <= 1'b0;
      r_igual     <= 1'b0;
      r_carry     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_estado    <= w_estado;
      r_a         <= w_a;
      r_b         <= w_b;
      r_op        <= w_op;
      r_cnt       <= w_cnt;
      r_hi        <= w_hi;
      r_lo        <= w_lo;
      r_pronto    <= w_pronto;
      r_valido    <= w_valido;
      r_resultado <= w_resultado;
      r_maior     <= w_maior;
      r_menor     <= w_menor;
      r_igual     <= w_igual;
      r_carry     <= w_carry;
      r_div_zero  <= w_div_zero;
      r_erro      <= w_erro;
    end
  end

  assign Pronto    = r_pronto;
  assign Valido    = r_valido;
  assign Resultado = r_resultado;
  assign Maior     = r_maior;
  assign Menor     = r_menor;
  assign Igual     = r_igual;
  assign Carry     = r_carry;
  assign Div_Zero  = r_div_zero;
  assign Erro      = r_erro;

endmodule

// File: tb/tb_ula_sequencial.sv
// Testbench for ula_sequencial (LARGURA=8): directed scenarios plus random
// operations checked against an arithmetic reference model.
module tb_ula_sequencial;

  localparam int unsigned W = 8;

  logic            clk;
  logic            rst;
  logic            Inicio;
  logic [W-1:0]    A, B;
  logic [3:0]      Sel_Op;
  logic            Pronto, Valido;
  logic [2*W-1:0]  Resultado;
  logic            Maior, Menor, Igual, Carry, Div_Zero, Erro;

  int n_checks = 0;
  int n_errors = 0;

  ula_sequencial #(.LARGURA(W)) dut (
    .clk(clk), .rst(rst), .Inicio(Inicio), .A(A), .B(B), .Sel_Op(Sel_Op),
    .Pronto(Pronto), .Valido(Valido), .Resultado(Resultado),
    .Maior(Maior), .Menor(Menor), .Igual(Igual), .Carry(Carry),
    .Div_Zero(Div_Zero), .Erro(Erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: flags packed as {Maior,Menor,Igual,Carry,Div_Zero,Erro}
  function automatic void modelo(input int a, input int b, input int op,
                                 output int res, output int lat, output logic [5:0] fl);
    int mask;
    logic c, dz, er;
    mask = (1 << W) - 1;
    res = 0; lat = 1; c = 0; dz = 0; er = 0;
    case (op)
      0: begin res = a + b; c = ((a + b) >> W) != 0; end
      1: begin res = (a - b) & mask; c = (a < b); end
      2: begin res = a * b; lat = W; end
`ifdef ULA_SEQ_DIVISOR_EN
      3: begin lat = W; dz = (b == 0); res = (b == 0) ? mask : a / b; end
      4: begin lat = W; dz = (b == 0); res = (b == 0) ? a : a % b; end
`endif
      5: res = 0;
      6: res = a & b;
      7: res = a | b;
      8: res = ~(a & b) & mask;
      9: res = ~(a | b) & mask;
      10: res = a ^ b;
      11: res = ~a & mask;
      default: begin res = 0; er = 1; end
    endcase
    fl = {a > b, a < b, a == b, c, dz, er};
  endfunction

  function automatic logic [5:0] flags_dut();
    return {Maior, Menor, Igual, Carry, Div_Zero, Erro};
  endfunction

  // Wait for Valido with a cycle budget; Pronto must stay low while busy
  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!Valido) check({tag, "_busy_pronto"}, 64'(Pronto), 64'(0));
    end while (!Valido && cyc < 100);
    if (!Valido) check({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  // Issue one op from an idle cycle and check latency, result and flags
  task automatic run_op(input int a, input int b, input int op, input string tag);
    int er, el, cyc;
    logic [5:0] ef;
    modelo(a, b, op, er, el, ef);
    A = W'(a); B = W'(b); Sel_Op = 4'(op); Inicio = 1'b1;
    @(posedge clk); #1;
    Inicio = 1'b0;
    check({tag, "_accept_pronto"}, 64'(Pronto), 64'(0));
    check({tag, "_accept_valido"}, 64'(Valido), 64'(0));
    wait_valid(tag, cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(el));
    check({tag, "_res"}, 64'(Resultado), 64'(er));
    check({tag, "_flags"}, 64'(flags_dut()), 64'(ef));
    check({tag, "_done_pronto"}, 64'(Pronto), 64'(1));
  endtask

  initial begin
    int cyc, seen, ra, rb, rop;
    rst = 1'b1; Inicio = 1'b0; A = '0; B = '0; Sel_Op = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_pronto", 64'(Pronto), 64'(1));
    check("rst_valido", 64'(Valido), 64'(0));
    check("rst_res", 64'(Resultado), 64'(0));
    check("rst_flags", 64'(flags_dut()), 64'(0));

    // Add with carry-out
    run_op(200, 100, 0, "add");
    check("add_const", 64'(Resultado), 64'h012C);

    // Multiply with a start request during execution that must be ignored
    A = 8'd255; B = 8'd255; Sel_Op = 4'd2; Inicio = 1'b1;
    @(posedge clk); #1;
    Inicio = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!Valido) check("mul_busy_pronto", 64'(Pronto), 64'(0));
      if (cyc == 3 && !Valido) begin
        Inicio = 1'b1; A = 8'd1; B = 8'd1; Sel_Op = 4'd0;
      end else begin
        Inicio = 1'b0;
      end
    end while (!Valido && cyc < 100);
    Inicio = 1'b0;
    check("mul_lat", 64'(cyc), 64'(8));
    check("mul_res", 64'(Resultado), 64'hFE01);
    @(posedge clk); #1;
    check("mul_noqueue_valido", 64'(Valido), 64'(0));
    check("mul_noqueue_pronto", 64'(Pronto), 64'(1));

`ifdef ULA_SEQ_DIVISOR_EN
    run_op(100, 7, 3, "quo");
    check("quo_const", 64'(Resultado), 64'h000E);
    run_op(100, 7, 4, "rem");
    check("rem_const", 64'(Resultado), 64'h0002);
    run_op(37, 0, 3, "quo_b0");
    check("quo_b0_const", 64'(Resultado), 64'h00FF);
    check("quo_b0_dz", 64'(Div_Zero), 64'(1));
    run_op(37, 0, 4, "rem_b0");
    check("rem_b0_const", 64'(Resultado), 64'h0025);
`else
    run_op(100, 7, 3, "quo_off");
    check("quo_off_err", 64'(Erro), 64'(1));
    check("quo_off_res", 64'(Resultado), 64'(0));
    run_op(100, 7, 4, "rem_off");
`endif

    // Reset in the middle of a multiply
    A = 8'd13; B = 8'd11; Sel_Op = 4'd2; Inicio = 1'b1;
    @(posedge clk); #1;
    Inicio = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_pronto", 64'(Pronto), 64'(1));
    check("rstmid_res", 64'(Resultado), 64'(0));
    check("rstmid_valido", 64'(Valido), 64'(0));
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (Valido) seen++; end
    check("rstmid_no_valido", 64'(seen), 64'(0));
    run_op(8'hF0, 8'h3C, 6, "and_after_rst");
    check("and_const", 64'(Resultado), 64'h0030);

    // Back-to-back with Inicio held, then invalid opcode
    A = 8'hAA; B = 8'hFF; Sel_Op = 4'b1010; Inicio = 1'b1;
    @(posedge clk); #1;
    wait_valid("b2b1", cyc);
    check("b2b1_lat", 64'(cyc), 64'(1));
    check("b2b1_res", 64'(Resultado), 64'h0055);
    @(posedge clk); #1;
    check("b2b_reaccept_pronto", 64'(Pronto), 64'(0));
    check("b2b_reaccept_valido", 64'(Valido), 64'(0));
    wait_valid("b2b2", cyc);
    check("b2b2_lat", 64'(cyc), 64'(1));
    check("b2b2_res", 64'(Resultado), 64'h0055);
    Sel_Op = 4'b1111;
    @(posedge clk); #1;
    Inicio = 1'b0;
    wait_valid("inv", cyc);
    check("inv_lat", 64'(cyc), 64'(1));
    check("inv_res", 64'(Resultado), 64'(0));
    check("inv_flags", 64'(flags_dut()), 64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}));

    // Random operations against the model
    for (int i = 0; i < 120; i++) begin
      ra  = int'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) rb = ra;
      rop = int'($urandom_range(0, 15));
      run_op(ra, rb, rop, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
